// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline-boundary register: modes, stall-bit owners, stage NOPs.
package pipe_stage_reg_pkg;

  localparam int unsigned PSR_MODE_STALL = 0;
  localparam int unsigned PSR_MODE_SKID  = 1;

  // Stall-vector bit owned by each stage; a boundary register uses its upstream stage's bit.
  localparam int unsigned PSR_STG_IF  = 1;
  localparam int unsigned PSR_STG_ID  = 2;
  localparam int unsigned PSR_STG_EX  = 3;
  localparam int unsigned PSR_STG_MEM = 4;
  localparam int unsigned PSR_STG_WB  = 5;

  localparam int unsigned PSR_OCC_W = 2;
  localparam int unsigned PSR_NOP_W = 32;

  // IF/ID bubble is a real no-op instruction (addi x0,x0,0); later stages zero their fields.
  localparam logic [PSR_NOP_W-1:0] PSR_NOP_IF_ID  = 32'h0000_0013;
  localparam logic [PSR_NOP_W-1:0] PSR_NOP_ID_EX  = '0;
  localparam logic [PSR_NOP_W-1:0] PSR_NOP_EX_MEM = '0;
  localparam logic [PSR_NOP_W-1:0] PSR_NOP_MEM_WB = '0;

  typedef enum logic [2:0] {
    PSR_SKC_HOLD,
    PSR_SKC_DRAIN_SKID,
    PSR_SKC_POP_REFILL,
    PSR_SKC_FILL_MAIN,
    PSR_SKC_FILL_SKID
  } psr_skid_sel_e;

  function automatic logic [PSR_OCC_W-1:0] psr_occ(input logic main_v, input logic skid_v);
    return PSR_OCC_W'(main_v) + PSR_OCC_W'(skid_v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline boundary register.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_skid_buf.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one beat of backpressure.
module pipe_stage_reg_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_W-1:0]    out_data_o,
  output logic [PSR_OCC_W-1:0] occupancy_o
);

  logic                 main_valid_q, main_valid_d;
  logic [DATA_W-1:0]    main_data_q,  main_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]    skid_data_q,  skid_data_d;
  logic [PSR_OCC_W-1:0] occ_q,        occ_d;

  logic          acc_c;
  logic          pop_c;
  psr_skid_sel_e sel_c;

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready_o = !skid_valid_q && rst && !flush;
  assign acc_c      = in_valid_i && in_ready_o;
  assign pop_c      = main_valid_q && out_ready_i;

  always_comb begin
    sel_c = PSR_SKC_HOLD;
    if (pop_c && skid_valid_q)        sel_c = PSR_SKC_DRAIN_SKID;
    else if (pop_c)                   sel_c = PSR_SKC_POP_REFILL;
    else if (acc_c && !main_valid_q)  sel_c = PSR_SKC_FILL_MAIN;
    else if (acc_c)                   sel_c = PSR_SKC_FILL_SKID;
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    case (sel_c)
      PSR_SKC_DRAIN_SKID: begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
      PSR_SKC_POP_REFILL: begin
        main_data_d  = in_data_i;
        main_valid_d = acc_c;
      end
      PSR_SKC_FILL_MAIN: begin
        main_data_d  = in_data_i;
        main_valid_d = 1'b1;
      end
      PSR_SKC_FILL_SKID: begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end
      default: ;
    endcase
    occ_d = psr_occ(main_valid_d, skid_valid_d);
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VALUE;
      occ_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign occupancy_o = occ_q;

  a_skid_needs_main: assert property (@(posedge clk) disable iff (!rst)
    skid_valid_q |-> main_valid_q);

  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (main_valid_q && !out_ready_i && !flush) |=> $stable(main_data_q));

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: legacy stall-vector latch or valid/ready skid buffer.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MODE      = PSR_MODE_STALL,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       STAGE_IDX = PSR_STG_ID,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  pipe_stage_reg_if.slave    bus
);

  logic                 in_ready_c;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [PSR_OCC_W-1:0] occupancy;

  // Each mode leaves some of stall/out_ready unread.
  logic unused_ok;
  assign unused_ok = ^{stall, bus.out_ready};

  if (MODE == PSR_MODE_SKID) begin : g_skid
    pipe_stage_reg_skid_buf #(
      .DATA_W   (DATA_W),
      .NOP_VALUE(NOP_VALUE)
    ) u_skid_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid_i (bus.in_valid),
      .in_ready_o (in_ready_c),
      .in_data_i  (bus.in_data),
      .out_valid_o(out_valid),
      .out_ready_i(bus.out_ready),
      .out_data_o (out_data),
      .occupancy_o(occupancy)
    );
  end else begin : g_stall
    logic              su;
    logic              sd;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;

    assign su = stall[STAGE_IDX];
    assign sd = stall[STAGE_IDX+1];

    // Upstream stalled alone -> bubble; both stalled -> hold; otherwise load (even invalid data).
    always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (su && !sd) begin
        out_valid_d = 1'b0;
        out_data_d  = NOP_VALUE;
      end else if (!su) begin
        out_valid_d = bus.in_valid;
        out_data_d  = bus.in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        out_valid_q <= 1'b0;
        out_data_q  <= NOP_VALUE;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign in_ready_c = !su && rst && !flush;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign occupancy  = PSR_OCC_W'(out_valid_q);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one STALL-mode and one SKID-mode instance, SKID traffic scoreboarded.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [5:0] stall;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW)) bs ();
  pipe_stage_reg_if #(.DATA_W(DW)) bk ();

  pipe_stage_reg #(
    .DATA_W(DW), .MODE(0), .STALL_W(6), .STAGE_IDX(2), .NOP_VALUE(NOP)
  ) u_stall (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .bus(bs.slave)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .MODE(1), .STALL_W(6), .STAGE_IDX(2), .NOP_VALUE(NOP)
  ) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .bus(bk.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        sb_hold = 1'b0;
  logic [31:0] sb_held = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Called at the negedge: inputs are final for the coming posedge, outputs show held state.
  task automatic sb_sample();
    logic [31:0] e;
    if (rst) begin
      chk("sb_occ", 32'(bk.occupancy), 32'(exp_q.size()));
      if (sb_hold) chk("sb_stable", bk.out_data, sb_held);
    end
    sb_hold = rst && !flush && bk.out_valid && !bk.out_ready;
    sb_held = bk.out_data;
    if (!rst || flush) begin
      exp_q.delete();
    end else begin
      if (bk.out_valid && bk.out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_data", bk.out_data, e);
        end
      end
      if (bk.in_valid && bk.in_ready) exp_q.push_back(bk.in_data);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall_out(input string tag, input logic v, input logic [31:0] d);
    chk({tag, "_v"}, 32'(bs.out_valid), 32'(v));
    chk({tag, "_d"}, bs.out_data, d);
    chk({tag, "_occ"}, 32'(bs.occupancy), 32'(v));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    bs.in_valid = 1'b1; bs.in_data = 32'hDEAD_BEEF; bs.out_ready = 1'b1;
    bk.in_valid = 1'b1; bk.in_data = 32'hDEAD_BEEF; bk.out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset held for two cycles with traffic presented
    repeat (2) begin
      step();
      chk("rst_s_v",   32'(bs.out_valid), 32'd0);
      chk("rst_s_d",   bs.out_data, NOP);
      chk("rst_s_occ", 32'(bs.occupancy), 32'd0);
      chk("rst_s_rdy", 32'(bs.in_ready), 32'd0);
      chk("rst_k_v",   32'(bk.out_valid), 32'd0);
      chk("rst_k_d",   bk.out_data, NOP);
      chk("rst_k_occ", 32'(bk.occupancy), 32'd0);
      chk("rst_k_rdy", 32'(bk.in_ready), 32'd0);
    end
    rst = 1'b1;
    bs.in_valid = 1'b0; bk.in_valid = 1'b0; bk.out_ready = 1'b0;
    #1;
    chk("rel_k_rdy", 32'(bk.in_ready), 32'd1);

    // STALL mode
    bs.in_valid = 1'b1; bs.in_data = 32'h11; stall = 6'b000000;
    step(); chk_stall_out("st_load", 1'b1, 32'h11);
    stall = 6'b000100; #1;
    chk("st_bub_rdy", 32'(bs.in_ready), 32'd0);
    step(); chk_stall_out("st_bubble", 1'b0, NOP);
    stall = 6'b001100; bs.in_data = 32'h55; #1;
    chk("st_hold_rdy", 32'(bs.in_ready), 32'd0);
    step(); chk_stall_out("st_hold_bub", 1'b0, NOP);
    stall = 6'b000000; bs.in_data = 32'h11; #1;
    chk("st_rel_rdy", 32'(bs.in_ready), 32'd1);
    step(); chk_stall_out("st_release", 1'b1, 32'h11);
    stall = 6'b001100; bs.in_data = 32'h22;
    step(); chk_stall_out("st_hold_data", 1'b1, 32'h11);
    stall = 6'b001000;
    step(); chk_stall_out("st_sd_only", 1'b1, 32'h22);
    stall = 6'b000000; bs.in_valid = 1'b0; bs.in_data = 32'h33;
    step(); chk_stall_out("st_invalid_ld", 1'b0, 32'h33);
    bs.in_valid = 1'b1; bs.in_data = 32'h44;
    step(); chk_stall_out("st_pre_flush", 1'b1, 32'h44);
    flush = 1'b1; bs.in_data = 32'h45; #1;
    chk("st_fl_rdy", 32'(bs.in_ready), 32'd0);
    chk("sk_fl_rdy", 32'(bk.in_ready), 32'd0);
    step(); chk_stall_out("st_flush", 1'b0, NOP);
    flush = 1'b0; bs.in_valid = 1'b0;

    // SKID backpressure
    bk.out_ready = 1'b0; bk.in_valid = 1'b1; bk.in_data = 32'hA1;
    step();
    chk("bp1_v",   32'(bk.out_valid), 32'd1);
    chk("bp1_d",   bk.out_data, 32'hA1);
    chk("bp1_occ", 32'(bk.occupancy), 32'd1);
    chk("bp1_rdy", 32'(bk.in_ready), 32'd1);
    bk.in_data = 32'hA2;
    step();
    chk("bp2_occ", 32'(bk.occupancy), 32'd2);
    chk("bp2_rdy", 32'(bk.in_ready), 32'd0);
    chk("bp2_d",   bk.out_data, 32'hA1);
    bk.in_valid = 1'b0;
    step();
    chk("bp3_occ", 32'(bk.occupancy), 32'd2);
    chk("bp3_d",   bk.out_data, 32'hA1);
    bk.out_ready = 1'b1;
    step();
    chk("bp4_v",   32'(bk.out_valid), 32'd1);
    chk("bp4_d",   bk.out_data, 32'hA2);
    chk("bp4_occ", 32'(bk.occupancy), 32'd1);
    chk("bp4_rdy", 32'(bk.in_ready), 32'd1);
    step();
    chk("bp5_v",   32'(bk.out_valid), 32'd0);
    chk("bp5_occ", 32'(bk.occupancy), 32'd0);

    // SKID throughput: every beat visible exactly one cycle after its accept
    for (int i = 0; i < 16; i++) begin
      bk.in_valid = 1'b1; bk.in_data = 32'(i);
      chk("tp_rdy", 32'(bk.in_ready), 32'd1);
      step();
      chk("tp_v", 32'(bk.out_valid), 32'd1);
      chk("tp_d", bk.out_data, 32'(i));
    end
    bk.in_valid = 1'b0;
    step();
    chk("tp_end_v", 32'(bk.out_valid), 32'd0);

    // Flush with both entries full and a beat presented
    bk.out_ready = 1'b0; bk.in_valid = 1'b1; bk.in_data = 32'hB1;
    step();
    bk.in_data = 32'hB2;
    step();
    chk("fl_pre_occ", 32'(bk.occupancy), 32'd2);
    bk.in_data = 32'hB3; flush = 1'b1;
    step();
    chk("fl_occ", 32'(bk.occupancy), 32'd0);
    chk("fl_v",   32'(bk.out_valid), 32'd0);
    flush = 1'b0; bk.in_valid = 1'b0; bk.out_ready = 1'b1;
    repeat (4) begin
      step();
      chk("fl_no_late", 32'(bk.out_valid), 32'd0);
    end

    // Random SKID traffic with occasional flush
    repeat (500) begin
      bk.in_valid  = ($urandom_range(0, 9) < 7);
      bk.in_data   = $urandom;
      bk.out_ready = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 99) < 2);
      step();
    end
    flush = 1'b0; bk.in_valid = 1'b0; bk.out_ready = 1'b1;
    for (int i = 0; i < 8 && bk.occupancy != 2'd0; i++) step();
    step();
    chk("drain_occ", 32'(bk.occupancy), 32'd0);
    chk("drain_sb",  32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-boundary register, the successor to the fixed-field ID/EX, EX/MEM and MEM/WB latches.
- Carries an opaque packed payload of DATA_W bits between two stages.
- Two selectable modes. STALL mode keeps the legacy stall-vector hold/bubble semantics. SKID mode uses a valid/ready handshake with a 2-entry skid buffer, giving full throughput and a registered in_ready.
- Adds a flush input, a valid bit per entry, and an occupancy output.

Parameters:
- DATA_W, 32: payload width in bits (packed stage fields).
- MODE, 0: 0 = STALL mode, 1 = SKID mode.
- STALL_W, 6: width of the stall vector.
- STAGE_IDX, 2: stall bit owned by the upstream stage. Legal range is 0..STALL_W-2; the downstream stage is STAGE_IDX+1.
- NOP_VALUE, 0: payload value driven for a bubble or after reset/flush (DATA_W bits).

Ports:
- clk, input, 1: clock; all state updates on the posedge.
- rst, input, 1: synchronous reset, active-low (asserted when 0, sampled on the clk posedge).
- flush, input, 1: kill all held entries (branch mispredict / exception).
- stall, input, STALL_W: pipeline stall vector. Used in STALL mode only; ignored in SKID mode.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: stage can accept the upstream payload.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: downstream payload valid.
- out_ready, input, 1: downstream accepts. Used in SKID mode only; ignored in STALL mode.
- out_data, output, DATA_W: registered payload to the downstream stage.
- occupancy, output, 2: number of valid entries held (0..2).

Behaviour:
- Priority per cycle: reset > flush > mode logic.
- Reset (rst==0 at posedge): out_valid=0, out_data=NOP_VALUE, occupancy=0, skid entry invalid with skid data=NOP_VALUE. in_ready reads 0 while rst==0.
- Flush (rst==1, flush==1): same state as reset. Any handshake in the same cycle is dropped. in_ready is combinationally 0 while flush==1.
- STALL mode, with su = stall[STAGE_IDX] and sd = stall[STAGE_IDX+1]:
  - su & !sd: insert a bubble next cycle (out_valid=0, out_data=NOP_VALUE).
  - su & sd: hold out_valid and out_data.
  - !su: load out_valid<=in_valid, out_data<=in_data. Data is loaded even when in_valid=0.
  - in_ready = !su & rst & !flush, combinational.
  - The skid entry is never used; occupancy = out_valid.
  - Latency is 1 cycle.
- SKID mode uses two entries: main (drives out_*) and skid.
  - in_ready = !skid_valid & rst & !flush. skid_valid is a register, so in_ready has no combinational path from out_ready.
  - acc = in_valid & in_ready; pop = out_valid & out_ready.
  - Case pop & skid_valid: main<=skid, skid_valid<=0. No accept is possible because in_ready=0.
  - Case pop & !skid_valid: main<=in_data and out_valid<=acc.
  - Case !pop & !out_valid & acc: main<=in_data, out_valid<=1.
  - Case !pop & out_valid & acc: skid<=in_data, skid_valid<=1, in_ready falls next cycle.
  - Otherwise: hold all state.
  - Ordering: strict FIFO; no payload is duplicated or dropped except by flush/reset.
  - Latency: 1 cycle from accept to out_valid when empty. Sustained throughput is 1 transfer/cycle while out_ready=1.
  - While out_valid=0, out_data is unspecified. The RTL leaves it at its last value or NOP_VALUE.
- occupancy = out_valid + skid_valid, registered. It never exceeds 2, and the skid entry is never valid while main is invalid.
- Reset or flush mid-transfer: all held payloads are discarded. Upstream re-presents them if required.
- Assertions: skid_valid implies out_valid; in SKID mode out_data is stable while out_valid & !out_ready.

Decomposition:
- The shared defines header holds NOP payload constants for each stage, the stall-bit index constants (ID=2, EX=3, ...) and the mode constants PSR_MODE_STALL/PSR_MODE_SKID.
- Stage-specific wrappers pack and unpack fields: the existing reg_id_ex ports concatenate into in_data.
- One natural sub-module is pipe_skid_buf, the 2-entry SKID datapath, instantiated under a generate when MODE==1.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF, in both modes. Required: out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=0.
- STALL mode, STAGE_IDX=2, in_data=0x11:
  - stall=6'b000100 for one cycle: required bubble, out_data=NOP_VALUE, out_valid=0.
  - then stall=6'b001100: required out_* held.
  - then stall=0: required out_data=0x11 next cycle.
- SKID backpressure: out_ready=0, then push 0xA1 and 0xA2. Required: occupancy=2 and in_ready=0. Then set out_ready=1. Required: 0xA1 then 0xA2 on consecutive cycles, and in_ready returns to 1.
- SKID throughput: out_ready=1, 16 back-to-back beats 0..15. Required: 16 consecutive out_valid cycles, in order, first beat 1 cycle after the first accept.
- Flush with occupancy=2 and in_valid=1 in the same cycle. Required next cycle: occupancy=0 and out_valid=0; the concurrent beat is not delivered later.
- Random SKID traffic against a scoreboard, with random out_ready: no loss, no duplication, and out_data stable while out_valid & !out_ready.
